// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control sequencer.
// Imported by the FSM and its ALU decoder.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    JAL,
    JALR,
    BRANCH,
    LUI,
    HALT
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctl_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10,
    RES_IMMEXT    = 2'b11
  } result_src_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } src_a_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_e;

  // States that hold a memory request open and so count toward the timeout.
  function automatic logic is_mem_wait(input state_e s);
    return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps op/func3/func7 to the ALU operation for EXECR/EXECI/BRANCH and
// flags opcodes or func3 values the datapath does not support.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output logic [2:0] alu_control,
  output logic       illegal
);

  // Only func7[5] (add/sub select) carries meaning here.
  logic unused_func7;
  assign unused_func7 = ^{func7[6], func7[4:0]};

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (op)
      OP_LOAD, OP_STORE: illegal = (func3 != 3'b010);
      OP_RTYPE: begin
        case (func3)
          3'b000:  alu_control = func7[5] ? ALU_SUB : ALU_ADD;
          3'b111:  alu_control = ALU_AND;
          3'b110:  alu_control = ALU_OR;
          3'b010:  alu_control = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      OP_ITYPE: begin
        case (func3)
          3'b000:  alu_control = ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        case (func3)
          3'b000, 3'b001: alu_control = ALU_SUB;
          3'b100, 3'b101: alu_control = ALU_SLT;
          default:        illegal = 1'b1;
        endcase
      end
      OP_JAL, OP_JALR, OP_LUI: illegal = 1'b0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Moore control sequencer for the multi-cycle RV32I datapath: steps each
// instruction through its states, stalls on mem_ready, halts on errors.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       instr_done,
  output logic       halted,
  output logic [1:0] error_code
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  err_e            err_q, err_d;

  logic [2:0] dec_alu;
  logic       dec_illegal;
  logic       waiting;
  logic       timeout_hit;

  mc_alu_decoder u_alu_dec (
    .op          (op),
    .func3       (func3),
    .func7       (func7),
    .alu_control (dec_alu),
    .illegal     (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FETCH;
      to_cnt_q <= '0;
      err_q    <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    waiting     = is_mem_wait(state_q);
    timeout_hit = (TIMEOUT_CYCLES != 0) && waiting && !mem_ready &&
                  (to_cnt_q == TO_LIMIT);
    to_cnt_d    = (waiting && !mem_ready && !timeout_hit) ? to_cnt_q + 1'b1 : '0;
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        if (dec_illegal) begin
          state_d = HALT;
          err_d   = ERR_ILLEGAL;
        end else begin
          case (op)
            OP_LOAD, OP_STORE: state_d = MEMADR;
            OP_RTYPE:          state_d = EXECR;
            OP_ITYPE:          state_d = EXECI;
            OP_JAL:            state_d = JAL;
            OP_JALR:           state_d = JALR;
            OP_BRANCH:         state_d = BRANCH;
            OP_LUI:            state_d = LUI;
            default: begin
              state_d = HALT;
              err_d   = ERR_ILLEGAL;
            end
          endcase
        end
      end
      MEMADR:   state_d = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (mem_ready) state_d = FETCH;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      JAL:      state_d = ALUWB;
      JALR:     state_d = JAL;
      BRANCH:   state_d = FETCH;
      LUI:      state_d = FETCH;
      HALT:     state_d = HALT;
      default:  state_d = HALT;
    endcase
    // A stalled access overrides whatever transition the state would take.
    if (timeout_hit) begin
      state_d = HALT;
      err_d   = ERR_TIMEOUT;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ALUControl = ALU_ADD;
    ImmSrc     = IMM_I;
    RegWrite   = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    error_code = err_q;
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_B;
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWRITE: begin
        mem_req    = 1'b1;
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
      end
      EXECR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUControl = dec_alu;
      end
      EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = dec_alu;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      JALR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUControl = dec_alu;
        instr_done = 1'b1;
        case (func3)
          3'b000:  PCWrite = Zero;
          3'b001:  PCWrite = ~Zero;
          3'b100:  PCWrite = ~Zero;
          3'b101:  PCWrite = Zero;
          default: PCWrite = 1'b0;
        endcase
      end
      LUI: begin
        ImmSrc     = IMM_U;
        ResultSrc  = RES_IMMEXT;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: halted = 1'b0;
    endcase
    // Reset gates everything so no strobe escapes while rst is low.
    if (!rst) begin
      mem_req    = 1'b0;
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      ResultSrc  = '0;
      ALUSrcA    = '0;
      ALUSrcB    = '0;
      ALUControl = '0;
      ImmSrc     = '0;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
      halted     = 1'b0;
      error_code = '0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed vector table, hand sequences for halt,
// reset and timeout, then random instructions against a trace-building model.
module tb_mc_control_fsm;

  localparam int TO = 4;

  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [6:0] JR = 7'b1100111;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] LU = 7'b0110111;

  typedef struct packed {
    logic       mem_req;
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] alu;
    logic [2:0] imm;
    logic       rw;
    logic       done;
    logic       halt;
    logic [1:0] err;
  } out_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z;
    logic       rdy;
    out_t       e;
    string      nm;
  } vec_t;

  logic       clk, rst;
  logic [6:0] op, func7;
  logic [2:0] func3;
  logic       Zero, mem_ready;
  logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic       instr_done, halted;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, error_code;
  logic [2:0] ALUControl, ImmSrc;

  int checks = 0;
  int fails  = 0;
  vec_t tbl[$];
  vec_t q[$];

  mc_control_fsm #(.TIMEOUT_CYCLES(TO), .TO_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
    .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .RegWrite(RegWrite), .instr_done(instr_done), .halted(halted),
    .error_code(error_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t O(input int mr, pw, ad, mw, ir, rs, sa, sb,
                             alu, imm, rw, dn, hl, er);
    out_t o;
    o.mem_req = 1'(mr); o.pcw = 1'(pw); o.adr = 1'(ad); o.mw = 1'(mw);
    o.irw = 1'(ir); o.rs = 2'(rs); o.sa = 2'(sa); o.sb = 2'(sb);
    o.alu = 3'(alu); o.imm = 3'(imm); o.rw = 1'(rw); o.done = 1'(dn);
    o.halt = 1'(hl); o.err = 2'(er);
    return o;
  endfunction

  function automatic vec_t V(input logic [6:0] o, input int f3, input logic [6:0] f7,
                             input logic z, input logic r, input out_t e, input string nm);
    vec_t v;
    v.op = o; v.f3 = 3'(f3); v.f7 = f7; v.z = z; v.rdy = r; v.e = e; v.nm = nm;
    return v;
  endfunction

  function automatic out_t get_out();
    return {mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
            ALUSrcB, ALUControl, ImmSrc, RegWrite, instr_done, halted, error_code};
  endfunction

  task automatic check(input string nm, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    op = v.op; func3 = v.f3; func7 = v.f7; Zero = v.z; mem_ready = v.rdy;
    #2;
    check(v.nm, get_out(), v.e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    check("reset_zero", get_out(), '0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // ---------------- reference model: instruction -> cycle trace ----------------
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic out_t fetch_o(input int r);
    return O(1, r, 0, 0, r, 2, 0, 2, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic out_t halt_o(input int er);
    return O(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, er);
  endfunction

  function automatic void push(input logic [6:0] o, input logic [2:0] f3,
                               input logic [6:0] f7, input logic z, input logic r,
                               input out_t e, input string nm);
    q.push_back(V(o, int'(f3), f7, z, r, e, nm));
  endfunction

  // A memory wait with n stall cycles either completes or times out into HALT.
  function automatic bit wait_ph(input logic [6:0] o, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic z, input int n,
                                 input out_t busy, input out_t fin, input string nm);
    if (n > TO) begin
      for (int i = 0; i < TO + 1; i++) push(o, f3, f7, z, 1'b0, busy, nm);
      for (int i = 0; i < 3; i++) push(o, f3, f7, z, rb(), halt_o(2), "timeout_halt");
      return 1'b1;
    end
    for (int i = 0; i < n; i++) push(o, f3, f7, z, 1'b0, busy, nm);
    push(o, f3, f7, z, 1'b1, fin, nm);
    return 1'b0;
  endfunction

  function automatic bit build(input logic [6:0] o, input logic [2:0] f3,
                               input logic [6:0] f7, input logic z, input int sf,
                               input int sm);
    bit   legal;
    int   alu;
    out_t aluwb = O(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    if (wait_ph(o, f3, f7, z, sf, fetch_o(0), fetch_o(1), "m_fetch")) return 1'b1;
    push(o, f3, f7, z, rb(), O(0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0, 0, 0), "m_decode");
    case (o)
      LW, SW:     legal = (f3 == 3'd2);
      RT, IT:     legal = f3 inside {3'd0, 3'd2, 3'd6, 3'd7};
      BR:         legal = f3 inside {3'd0, 3'd1, 3'd4, 3'd5};
      JL, JR, LU: legal = 1'b1;
      default:    legal = 1'b0;
    endcase
    if (!legal) begin
      for (int i = 0; i < 3; i++) push(o, f3, f7, z, rb(), halt_o(1), "m_illegal");
      return 1'b1;
    end
    case (f3)
      3'd2:    alu = 5;
      3'd6:    alu = 3;
      3'd7:    alu = 2;
      default: alu = (o == RT && f7[5]) ? 1 : 0;
    endcase
    case (o)
      LW: begin
        push(o, f3, f7, z, rb(), O(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0), "m_lw_adr");
        if (wait_ph(o, f3, f7, z, sm, O(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                    O(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "m_memread")) return 1'b1;
        push(o, f3, f7, z, rb(), O(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0), "m_memwb");
      end
      SW: begin
        push(o, f3, f7, z, rb(), O(0, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0, 0, 0), "m_sw_adr");
        if (wait_ph(o, f3, f7, z, sm, O(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                    O(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "m_memwrite")) return 1'b1;
      end
      RT: begin
        push(o, f3, f7, z, rb(), O(0, 0, 0, 0, 0, 0, 2, 0, alu, 0, 0, 0, 0, 0), "m_execr");
        push(o, f3, f7, z, rb(), aluwb, "m_aluwb");
      end
      IT: begin
        push(o, f3, f7, z, rb(), O(0, 0, 0, 0, 0, 0, 2, 1, alu, 0, 0, 0, 0, 0), "m_execi");
        push(o, f3, f7, z, rb(), aluwb, "m_aluwb");
      end
      JR, JL: begin
        if (o == JR)
          push(o, f3, f7, z, rb(), O(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0), "m_jalr");
        push(o, f3, f7, z, rb(), O(0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0), "m_jal");
        push(o, f3, f7, z, rb(), aluwb, "m_aluwb");
      end
      BR: begin
        // beq/bge take the branch on Zero, bne/blt on not-Zero
        push(o, f3, f7, z, rb(),
             O(0, (f3 == 3'd0 || f3 == 3'd5) ? int'(z) : int'(!z), 0, 0, 0, 0, 2, 0,
               (f3 < 3'd4) ? 1 : 5, 0, 0, 1, 0, 0), "m_branch");
      end
      default: begin
        push(o, f3, f7, z, rb(), O(0, 0, 0, 0, 0, 3, 0, 0, 0, 4, 1, 1, 0, 0), "m_lui");
      end
    endcase
    return 1'b0;
  endfunction

  function automatic int stall();
    return ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 6);
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [6:0] rop;
    logic [2:0] rf3;
    logic [6:0] legal_ops[8];
    bit         died;

    legal_ops = '{LW, SW, RT, IT, JL, JR, BR, LU};

    // add x3,x1,x2 / sub
    tbl.push_back(V(RT, 0, 7'h00, 0, 1, O(1,1,0,0,1, 2,0,2, 0,0, 0,0,0,0), "add_fetch"));
    tbl.push_back(V(RT, 0, 7'h00, 0, 0, O(0,0,0,0,0, 0,1,1, 0,2, 0,0,0,0), "add_decode"));
    tbl.push_back(V(RT, 0, 7'h00, 0, 1, O(0,0,0,0,0, 0,2,0, 0,0, 0,0,0,0), "add_execr"));
    tbl.push_back(V(RT, 0, 7'h00, 0, 0, O(0,0,0,0,0, 0,0,0, 0,0, 1,1,0,0), "add_aluwb"));
    tbl.push_back(V(RT, 0, 7'h20, 0, 1, O(1,1,0,0,1, 2,0,2, 0,0, 0,0,0,0), "sub_fetch"));
    tbl.push_back(V(RT, 0, 7'h20, 0, 0, O(0,0,0,0,0, 0,1,1, 0,2, 0,0,0,0), "sub_decode"));
    tbl.push_back(V(RT, 0, 7'h20, 0, 0, O(0,0,0,0,0, 0,2,0, 1,0, 0,0,0,0), "sub_execr"));
    tbl.push_back(V(RT, 0, 7'h20, 0, 0, O(0,0,0,0,0, 0,0,0, 0,0, 1,1,0,0), "sub_aluwb"));
    // lw with 3 stall cycles in MEMREAD: 8 cycles total
    tbl.push_back(V(LW, 2, 7'h00, 0, 1, O(1,1,0,0,1, 2,0,2, 0,0, 0,0,0,0), "lw_fetch"));
    tbl.push_back(V(LW, 2, 7'h00, 0, 0, O(0,0,0,0,0, 0,1,1, 0,2, 0,0,0,0), "lw_decode"));
    tbl.push_back(V(LW, 2, 7'h00, 0, 1, O(0,0,0,0,0, 0,2,1, 0,0, 0,0,0,0), "lw_memadr"));
    for (int i = 0; i < 3; i++)
      tbl.push_back(V(LW, 2, 7'h00, 0, 0, O(1,0,1,0,0, 0,0,0, 0,0, 0,0,0,0), "lw_stall"));
    tbl.push_back(V(LW, 2, 7'h00, 0, 1, O(1,0,1,0,0, 0,0,0, 0,0, 0,0,0,0), "lw_memread"));
    tbl.push_back(V(LW, 2, 7'h00, 0, 0, O(0,0,0,0,0, 1,0,0, 0,0, 1,1,0,0), "lw_memwb"));
    // sw, one fetch stall then single-cycle MEMWRITE
    tbl.push_back(V(SW, 2, 7'h00, 0, 0, O(1,0,0,0,0, 2,0,2, 0,0, 0,0,0,0), "sw_fetch_stall"));
    tbl.push_back(V(SW, 2, 7'h00, 0, 1, O(1,1,0,0,1, 2,0,2, 0,0, 0,0,0,0), "sw_fetch"));
    tbl.push_back(V(SW, 2, 7'h00, 0, 0, O(0,0,0,0,0, 0,1,1, 0,2, 0,0,0,0), "sw_decode"));
    tbl.push_back(V(SW, 2, 7'h00, 0, 0, O(0,0,0,0,0, 0,2,1, 0,1, 0,0,0,0), "sw_memadr"));
    tbl.push_back(V(SW, 2, 7'h00, 0, 1, O(1,0,1,1,0, 0,0,0, 0,0, 0,1,0,0), "sw_memwrite"));
    // beq Z=1, blt Z=1
    tbl.push_back(V(BR, 0, 7'h00, 1, 1, O(1,1,0,0,1, 2,0,2, 0,0, 0,0,0,0), "beq_fetch"));
    tbl.push_back(V(BR, 0, 7'h00, 1, 0, O(0,0,0,0,0, 0,1,1, 0,2, 0,0,0,0), "beq_decode"));
    tbl.push_back(V(BR, 0, 7'h00, 1, 0, O(0,1,0,0,0, 0,2,0, 1,0, 0,1,0,0), "beq_branch"));
    tbl.push_back(V(BR, 4, 7'h00, 1, 1, O(1,1,0,0,1, 2,0,2, 0,0, 0,0,0,0), "blt_fetch"));
    tbl.push_back(V(BR, 4, 7'h00, 1, 0, O(0,0,0,0,0, 0,1,1, 0,2, 0,0,0,0), "blt_decode"));
    tbl.push_back(V(BR, 4, 7'h00, 1, 1, O(0,0,0,0,0, 0,2,0, 5,0, 0,1,0,0), "blt_branch"));
    // jalr -> JALR, JAL, ALUWB
    tbl.push_back(V(JR, 0, 7'h00, 0, 1, O(1,1,0,0,1, 2,0,2, 0,0, 0,0,0,0), "jalr_fetch"));
    tbl.push_back(V(JR, 0, 7'h00, 0, 0, O(0,0,0,0,0, 0,1,1, 0,2, 0,0,0,0), "jalr_decode"));
    tbl.push_back(V(JR, 0, 7'h00, 0, 0, O(0,0,0,0,0, 0,2,1, 0,0, 0,0,0,0), "jalr_jalr"));
    tbl.push_back(V(JR, 0, 7'h00, 0, 0, O(0,1,0,0,0, 0,1,2, 0,0, 0,0,0,0), "jalr_jal"));
    tbl.push_back(V(JR, 0, 7'h00, 0, 0, O(0,0,0,0,0, 0,0,0, 0,0, 1,1,0,0), "jalr_aluwb"));
    // lui
    tbl.push_back(V(LU, 0, 7'h00, 0, 1, O(1,1,0,0,1, 2,0,2, 0,0, 0,0,0,0), "lui_fetch"));
    tbl.push_back(V(LU, 0, 7'h00, 0, 0, O(0,0,0,0,0, 0,1,1, 0,2, 0,0,0,0), "lui_decode"));
    tbl.push_back(V(LU, 0, 7'h00, 0, 0, O(0,0,0,0,0, 3,0,0, 0,4, 1,1,0,0), "lui_lui"));
    // illegal opcode
    tbl.push_back(V(7'h7f, 0, 7'h00, 0, 1, O(1,1,0,0,1, 2,0,2, 0,0, 0,0,0,0), "ill_fetch"));
    tbl.push_back(V(7'h7f, 0, 7'h00, 0, 0, O(0,0,0,0,0, 0,1,1, 0,2, 0,0,0,0), "ill_decode"));
    tbl.push_back(V(7'h7f, 0, 7'h00, 0, 1, O(0,0,0,0,0, 0,0,0, 0,0, 0,0,1,1), "ill_halt"));

    rst = 1'b0; op = '0; func3 = '0; func7 = '0; Zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    check("reset_state", get_out(), '0);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // HALT is absorbing regardless of inputs
    for (int i = 0; i < 20; i++)
      apply(V(7'($urandom), $urandom_range(0, 7), 7'($urandom), rb(), rb(),
              O(0,0,0,0,0, 0,0,0, 0,0, 0,0,1,1), "halt_hold"));
    do_reset();
    apply(V(RT, 0, 7'h00, 0, 0, O(1,0,0,0,0, 2,0,2, 0,0, 0,0,0,0), "restart_fetch"));
    do_reset();

    // timeout: 5 stalled FETCH cycles with normal outputs, then HALT/10
    for (int i = 0; i < TO + 1; i++)
      apply(V(RT, 0, 7'h00, 0, 0, O(1,0,0,0,0, 2,0,2, 0,0, 0,0,0,0), "to_fetch"));
    apply(V(RT, 0, 7'h00, 0, 1, O(0,0,0,0,0, 0,0,0, 0,0, 0,0,1,2), "to_halt"));
    apply(V(RT, 0, 7'h00, 0, 0, O(0,0,0,0,0, 0,0,0, 0,0, 0,0,1,2), "to_halt_hold"));
    do_reset();

    // exactly TO stalls still completes
    for (int i = 0; i < TO; i++)
      apply(V(LU, 0, 7'h00, 0, 0, O(1,0,0,0,0, 2,0,2, 0,0, 0,0,0,0), "edge_stall"));
    apply(V(LU, 0, 7'h00, 0, 1, O(1,1,0,0,1, 2,0,2, 0,0, 0,0,0,0), "edge_fetch"));
    apply(V(LU, 0, 7'h00, 0, 0, O(0,0,0,0,0, 0,1,1, 0,2, 0,0,0,0), "edge_decode"));
    apply(V(LU, 0, 7'h00, 0, 0, O(0,0,0,0,0, 3,0,0, 0,4, 1,1,0,0), "edge_lui"));

    // reset mid-MEMWRITE kills strobes immediately
    apply(V(SW, 2, 7'h00, 0, 1, O(1,1,0,0,1, 2,0,2, 0,0, 0,0,0,0), "mid_fetch"));
    apply(V(SW, 2, 7'h00, 0, 0, O(0,0,0,0,0, 0,1,1, 0,2, 0,0,0,0), "mid_decode"));
    apply(V(SW, 2, 7'h00, 0, 0, O(0,0,0,0,0, 0,2,1, 0,1, 0,0,0,0), "mid_memadr"));
    mem_ready = 1'b0;
    #2;
    check("mid_memwrite", get_out(), O(1,0,1,1,0, 0,0,0, 0,0, 0,0,0,0));
    rst = 1'b0;
    #1;
    check("mid_reset_zero", get_out(), '0);
    @(posedge clk); #1;
    rst = 1'b1;
    apply(V(SW, 2, 7'h00, 0, 0, O(1,0,0,0,0, 2,0,2, 0,0, 0,0,0,0), "mid_refetch"));
    do_reset();

    // random instruction stream against the trace model
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        do rop = 7'($urandom); while (rop inside {LW, SW, RT, IT, JL, JR, BR, LU});
      end else begin
        rop = legal_ops[$urandom_range(0, 7)];
      end
      rf3 = 3'($urandom_range(0, 7));
      if ((rop == LW || rop == SW) && $urandom_range(0, 3) != 0) rf3 = 3'd2;
      died = build(rop, rf3, 7'($urandom), rb(), stall(), stall());
      while (q.size() > 0) apply(q.pop_front());
      if (died) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Control sequencer for the multi-cycle RV32I datapath variant: one register file, one shared instruction/data memory, and IR/OldPC/ALUOut/Data holding registers.
- Decodes op/func3/func7 from the IR and steps each instruction through a Moore state machine.
- Drives every datapath select and write strobe, and stalls on a memory ready handshake.
- Detects illegal instructions and memory timeouts, then halts.

Parameters:
TIMEOUT_CYCLES, 255, max consecutive cycles waiting on mem_ready before error halt; 0 disables the timeout
TO_W, 8, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2^TO_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
op  in  7  IR[6:0]
func3  in  3  IR[14:12]
func7  in  7  IR[31:25]
Zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request (FETCH, MEMREAD, MEMWRITE)
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  IR and OldPC enable
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 register
ALUSrcB  out  2  00 rs2 register, 01 ImmExt, 10 constant 4
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
RegWrite  out  1  register file write enable
instr_done  out  1  one-cycle pulse in the final state of each instruction
halted  out  1  FSM is in HALT
error_code  out  2  00 none, 01 illegal instruction, 10 memory timeout; holds until reset

Behaviour:
- Reset (rst=0, asynchronous): state=FETCH, timeout count=0, error_code=00. While rst=0 all outputs are forced to 0.
- Outputs are combinational from the state plus the IR fields. All unlisted outputs are 0.
- FETCH:
  - Drives mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - If mem_ready=1: IRWrite=1 and PCWrite=1, then go to DECODE.
  - Otherwise stay in FETCH with IRWrite=PCWrite=0.
- DECODE:
  - Drives ALUSrcA=01, ALUSrcB=01, ImmSrc=010, add (branch target into ALUOut).
  - Next state by op: 0000011 MEMADR; 0100011 MEMADR; 0110011 EXECR; 0010011 EXECI; 1101111 JAL; 1100111 JALR; 1100011 BRANCH; 0110111 LUI.
  - Any other op, or an unsupported func3 (listed below), goes to HALT with error_code=01.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add, ImmSrc = 000 for lw / 001 for sw. Next is MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: mem_req=1, AdrSrc=1. Go to MEMWB on mem_ready.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Next is FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1 in every cycle of the state. The write commits on the mem_ready cycle; instr_done=1 on that cycle; then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00. func3 000 → add, or sub when func7[5]=1; 111 and; 110 or; 010 slt. Next is ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=000. func3 000 add, 010 slt, 110 or, 111 and. Next is ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. Next is FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Next is ALUWB, which writes rd = OldPC+4.
- JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, add (target into ALUOut). Next is JAL.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, ResultSrc=00, instr_done=1.
  - beq (000) and bne (001) use sub; blt (100) and bge (101) use slt.
  - PCWrite = Zero for beq; ~Zero for bne; ~Zero for blt; Zero for bge.
  - Next is FETCH.
- LUI: ImmSrc=100, ResultSrc=11, RegWrite=1, instr_done=1. Next is FETCH.
- lw and sw require func3=010; anything else is illegal.
- HALT: absorbing state; halted=1, no strobes. Only reset leaves it.
- Timeout counter:
  - Increments every cycle spent in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
  - Clears on mem_ready=1 or on leaving those states.
  - When the count reaches TIMEOUT_CYCLES with mem_ready still 0, the next state is HALT with error_code=10. Outputs stay normal in that last cycle.
- mem_ready in any state that does not assert mem_req is ignored.
- Reset asserted mid-instruction aborts the instruction. No partial strobe is issued after rst falls.

Decomposition:
- Package mc_ctrl_pkg:
  - state enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, JALR, BRANCH, LUI, HALT.
  - opcode constants.
  - ALUControl, ImmSrc, ResultSrc, ALUSrcA and ALUSrcB encodings.
  - error_code values.
- One sub-module, mc_alu_decoder: combinational mapping of op/func3/func7 to ALUControl plus an illegal flag. The FSM instantiates it.

Test Plan:
- Reset release, mem_ready=1, add x3,x1,x2 → FETCH, DECODE, EXECR, ALUWB.
  - Required: ALUControl=000 in EXECR; RegWrite=1 and instr_done=1 in ALUWB; PCWrite pulses once in FETCH.
- lw with mem_ready low for 3 cycles in MEMREAD → 3 stall cycles, then MEMWB with ResultSrc=01 and RegWrite=1; total 8 cycles.
- sw → MemWrite=1 for the whole of MEMWRITE; a single mem_ready cycle gives a 4-cycle instruction.
- beq with Zero=1 → PCWrite=1 in BRANCH.
- blt with Zero=1 → PCWrite=0 and ALUControl=101.
- jalr → JALR, JAL, ALUWB sequence. Required: PCWrite=1 in JAL with ResultSrc=00; RegWrite=1 in ALUWB.
- Error paths:
  - op=1111111 → HALT with error_code=01 and halted=1, held for 20 cycles; rst low then high restarts in FETCH.
  - TIMEOUT_CYCLES=4 with mem_ready held 0 in FETCH → HALT with error_code=10 after 5 cycles.
